generador_nota: RTL



---
 rtl/generador_nota_if.sv | 28 ++
 rtl/generador_nota.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/generador_nota_if.sv
// Command channel between the song sequencer and the tone generator.
// Latency: none, wires only.
// Backpressure: nota_ready from the generator; commands are held by the sequencer until accepted.
interface generador_nota_if;
    logic        nota_valid;
    logic        nota_ready;
    logic [3:0]  nota;
    logic [1:0]  octava;
    logic [11:0] duracion_ms;

    // Sequencer side
    modport master (
        output nota_valid,
        output nota,
        output octava,
        output duracion_ms,
        input  nota_ready
    );

    // Tone generator side
    modport slave (
        input  nota_valid,
        input  nota,
        input  octava,
        input  duracion_ms,
        output nota_ready
    );
endinterface

// File: rtl/generador_nota.sv
// Square-wave note generator: plays one (nota, octava, duracion_ms) command, then a fixed silent gap.
// Latency: PLAY starts the cycle after accept; first rising edge of audio_out H cycles later.
// Backpressure: nota_ready is high only in IDLE; valid while busy is ignored, never queued.
module generador_nota #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned GAP_MS = 10
) (
    input  logic                   reloj,
    input  logic                   reset_n,
    generador_nota_if.slave        cmd,
    output logic                   audio_out,
    output logic                   sonando
);

    // Reloj cycles per millisecond. The prescaler is 16 bits, so CLK_HZ must stay below ~65 MHz;
    // the half-period counter is 17 bits, which also holds the octave-4 C at that limit.
    localparam int unsigned MS_DIV    = CLK_HZ / 1000;
    localparam logic [15:0] PRESC_TOP = 16'(MS_DIV - 1);
    // The gap reuses the 12-bit millisecond counter, so GAP_MS is limited to 4095.
    localparam logic [11:0] GAP_LEN   = 12'(GAP_MS);

    // Octave-4 half-period for note index idx, rounded to the nearest cycle.
    // Frequencies are in micro-hertz so the rounding matches the real-valued definition.
    // Indices 12..15 are rests; they get a dummy half-period of 1 and never toggle.
    function automatic logic [16:0] half_of(input int idx);
        longint unsigned f_uhz;
        longint unsigned num;
        case (idx)
            0:       f_uhz = 64'd261625565;  // C
            1:       f_uhz = 64'd277182631;  // C#
            2:       f_uhz = 64'd293664768;  // D
            3:       f_uhz = 64'd311126984;  // D#
            4:       f_uhz = 64'd329627557;  // E
            5:       f_uhz = 64'd349228231;  // F
            6:       f_uhz = 64'd369994423;  // F#
            7:       f_uhz = 64'd391995436;  // G
            8:       f_uhz = 64'd415304698;  // G#
            9:       f_uhz = 64'd440000000;  // A
            10:      f_uhz = 64'd466163762;  // A#
            11:      f_uhz = 64'd493883301;  // B
            default: f_uhz = 64'd0;
        endcase
        if (f_uhz == 64'd0) begin
            return 17'd1;
        end
        num = 64'(CLK_HZ) * 64'd1_000_000 + f_uhz;
        return 17'(num / (64'd2 * f_uhz));
    endfunction

    localparam logic [16:0] H0_TAB [16] = '{
        half_of(0),  half_of(1),  half_of(2),  half_of(3),
        half_of(4),  half_of(5),  half_of(6),  half_of(7),
        half_of(8),  half_of(9),  half_of(10), half_of(11),
        half_of(12), half_of(13), half_of(14), half_of(15)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state;
    logic [16:0] reload_q;   // H-1 for the latched note and octave
    logic        rest_q;     // latched note is a rest
    logic [16:0] half_cnt;
    logic [15:0] presc;
    logic [11:0] ms_cnt;
    logic        ready_q;

    logic [16:0] h_sel;
    logic        rest_in;

    // Half-period for the command on the inputs, only meaningful on the accept edge.
    always_comb begin
        h_sel   = H0_TAB[cmd.nota] >> cmd.octava;
        rest_in = (cmd.nota >= 4'd12);
    end

    assign cmd.nota_ready = ready_q;

    // Command FSM with tone, prescaler and millisecond counters; all outputs registered.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            reload_q  <= '0;
            rest_q    <= 1'b0;
            half_cnt  <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            ready_q   <= 1'b1;
            audio_out <= 1'b0;
            sonando   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready_q is high throughout IDLE, so valid alone means accept.
                    if (cmd.nota_valid) begin
                        reload_q  <= h_sel - 17'd1;
                        rest_q    <= rest_in;
                        half_cnt  <= h_sel - 17'd1;
                        presc     <= PRESC_TOP;
                        audio_out <= 1'b0;
                        ready_q   <= 1'b0;
                        if (cmd.duracion_ms != 12'd0) begin
                            state   <= PLAY;
                            ms_cnt  <= cmd.duracion_ms;
                            sonando <= !rest_in;
                        end else begin
                            // Zero-length note: no sound, straight into the silent gap.
                            state   <= GAP;
                            ms_cnt  <= GAP_LEN;
                            sonando <= 1'b0;
                        end
                    end
                end

                PLAY: begin
                    if (half_cnt == 17'd0) begin
                        half_cnt <= reload_q;
                        if (!rest_q) begin
                            audio_out <= ~audio_out;
                        end
                    end else begin
                        half_cnt <= half_cnt - 17'd1;
                    end

                    if (presc == 16'd0) begin
                        presc <= PRESC_TOP;
                        if (ms_cnt == 12'd1) begin
                            // Last PLAY cycle: leaving for GAP overrides any toggle due now.
                            state     <= GAP;
                            ms_cnt    <= GAP_LEN;
                            audio_out <= 1'b0;
                            sonando   <= 1'b0;
                        end else begin
                            ms_cnt <= ms_cnt - 12'd1;
                        end
                    end else begin
                        presc <= presc - 16'd1;
                    end
                end

                GAP: begin
                    audio_out <= 1'b0;
                    sonando   <= 1'b0;
                    // A zero-length gap still spends one cycle here.
                    if ((ms_cnt == 12'd0) || ((presc == 16'd0) && (ms_cnt == 12'd1))) begin
                        state    <= IDLE;
                        ready_q  <= 1'b1;
                        ms_cnt   <= '0;
                        presc    <= '0;
                        half_cnt <= '0;
                    end else if (presc == 16'd0) begin
                        presc  <= PRESC_TOP;
                        ms_cnt <= ms_cnt - 12'd1;
                    end else begin
                        presc <= presc - 16'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
